fuser_fold_scheduler: RTL and testbench

//  Feeds per-modality folded hypervector streams into the folded majority fuser, one fold beat per cycle.

---
 rtl/fuser_fold_scheduler_pkg.sv | 23 ++
 rtl/fuser_fold_scheduler_if.sv | 40 ++++
 rtl/fuser_fold_scheduler_rr_arbiter.sv | 81 ++++++++
 rtl/fuser_fold_scheduler.sv | 150 +++++++++++++++
 tb/tb_fuser_fold_scheduler.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fuser_fold_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fuser_sched_pkg
//  Description : Shared types and helpers for the folded-fuser scheduler.
//                Provides the scheduler state encoding and the helper that
//                sizes the per-modality fold counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package fuser_sched_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        EMIT    = 2'd2
    } sched_state_t;

    // Width needed to hold the value n itself (0..n inclusive).
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fuser_fold_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : fuser_fold_scheduler_if
//  Description : Bundles the encoder-side request streams, the fuser-side
//                fold stream, and the fused-output handshake of the scheduler.
//                master : environment (encoders, fuser, downstream consumer)
//                slave  : the scheduler itself
//  Signals     : mod_valid/mod_ready/mod_hv   encoder fold beats
//                fuse_valid/fuse_ready/fuse_hv/fuse_fold/fuse_done  to fuser
//                out_ready                    downstream ready
//                busy                         sample in progress
//  Revision    : 1.0 - initial release
// ============================================================================
interface fuser_fold_scheduler_if #(
    parameter int NUM_MODALITY    = 3,
    parameter int NUM_FOLDS_WIDTH = 4,
    parameter int FOLD_WIDTH      = 200
);
    logic [NUM_MODALITY-1:0]            mod_valid;
    logic [NUM_MODALITY-1:0]            mod_ready;
    logic [NUM_MODALITY*FOLD_WIDTH-1:0] mod_hv;
    logic                               fuse_valid;
    logic                               fuse_ready;
    logic [FOLD_WIDTH-1:0]              fuse_hv;
    logic [NUM_FOLDS_WIDTH-1:0]         fuse_fold;
    logic                               fuse_done;
    logic                               out_ready;
    logic                               busy;

    modport master (
        output mod_valid, mod_hv, fuse_ready, out_ready,
        input  mod_ready, fuse_valid, fuse_hv, fuse_fold, fuse_done, busy
    );

    modport slave (
        input  mod_valid, mod_hv, fuse_ready, out_ready,
        output mod_ready, fuse_valid, fuse_hv, fuse_fold, fuse_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/fuser_fold_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Picks one requester per cycle. Returns a one-hot grant, the
//                binary index of the winner and a grant-present flag.
//                With FUSER_SCHED_RR_EN defined the search starts at a
//                rotating pointer that moves past each winner; otherwise the
//                lowest requesting index wins.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                req        request vector
//                gnt        one-hot grant
//                idx        index of granted requester
//                gnt_any    a grant was issued
//  Config      : FUSER_SCHED_RR_EN - round-robin priority
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [N-1:0]     req,
    output logic      [N-1:0]     gnt,
    output logic      [IDX_W-1:0] idx,
    output logic                  gnt_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

`ifdef FUSER_SCHED_RR_EN
    localparam logic [IDX_W:0]   c_N_EXT = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] c_LAST  = IDX_W'(N - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (gnt_any) begin
            r_ptr <= (idx == c_LAST) ? '0 : idx + IDX_W'(1);
        end
    end
`else
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;
`endif

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
`ifdef FUSER_SCHED_RR_EN
        w_sum   = '0;
`endif
        for (int k = 0; k < N; k++) begin
`ifdef FUSER_SCHED_RR_EN
            // Walk requesters starting from the pointer, wrapping at N.
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_N_EXT) begin
                w_sum = w_sum - c_N_EXT;
            end
            w_pos = w_sum[IDX_W-1:0];
`else
            w_pos = IDX_W'(k);
`endif
            if (!w_found && req[w_pos]) begin
                w_found    = 1'b1;
                gnt[w_pos] = 1'b1;
                idx        = w_pos;
            end
        end
    end

    assign gnt_any = w_found;

endmodule
`default_nettype wire

// File: rtl/fuser_fold_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fuser_fold_scheduler
//  Description : Streams per-modality folded hypervectors into the folded
//                majority fuser, one fold beat per cycle, tagging each beat
//                with the fold index of its modality. After every modality
//                has delivered all folds and the last beat has left the
//                output register, fuse_done is pulsed for exactly one
//                consumer-ready cycle to close the sample.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                bus        fuser_fold_scheduler_if.slave (encoder streams,
//                           fuser stream, done/out_ready, busy)
//  Config      : FUSER_SCHED_RR_EN - round-robin arbitration between
//                modalities (default: fixed priority, lowest index wins)
//  Revision    : 1.0 - initial release
// ============================================================================
module fuser_fold_scheduler
    import fuser_sched_pkg::*;
#(
    parameter int NUM_MODALITY    = 3,
    parameter int NUM_FOLDS       = 10,
    parameter int NUM_FOLDS_WIDTH = 4,
    parameter int FOLD_WIDTH      = 200
) (
    input wire logic clk,
    input wire logic rst,
    fuser_fold_scheduler_if.slave bus
);

    localparam int c_CNT_W = clog2p1(NUM_FOLDS);
    localparam int c_IDX_W = (NUM_MODALITY > 1) ? $clog2(NUM_MODALITY) : 1;

    localparam logic [c_CNT_W-1:0] c_FOLDS     = c_CNT_W'(NUM_FOLDS);
    localparam logic [c_CNT_W:0]   c_FOLDS_EXT = (c_CNT_W+1)'(NUM_FOLDS);

    localparam logic [1:0] c_COLLECT = COLLECT;
    localparam logic [1:0] c_DRAIN   = DRAIN;
    localparam logic [1:0] c_EMIT    = EMIT;

    logic [1:0]                 r_state;
    logic [c_CNT_W-1:0]         r_fcnt [NUM_MODALITY];
    logic                       r_fuse_valid;
    logic [FOLD_WIDTH-1:0]      r_fuse_hv;
    logic [NUM_FOLDS_WIDTH-1:0] r_fuse_fold;

    logic [FOLD_WIDTH-1:0]      w_hv [NUM_MODALITY];
    logic [NUM_MODALITY-1:0]    w_elig;
    logic [NUM_MODALITY-1:0]    w_req;
    logic [NUM_MODALITY-1:0]    w_gnt;
    logic [c_IDX_W-1:0]         w_idx;
    logic                       w_any;
    logic                       w_free;
    logic                       w_all_full;
    logic                       w_any_cnt;
    logic                       w_emit_fire;

    // Eligibility is gated by rst so no beat is acknowledged while the
    // sample is being aborted.
    for (genvar m = 0; m < NUM_MODALITY; m++) begin : g_mod
        assign w_hv[m]   = bus.mod_hv[m*FOLD_WIDTH +: FOLD_WIDTH];
        assign w_elig[m] = !rst && (r_state == c_COLLECT) && bus.mod_valid[m]
                           && (r_fcnt[m] < c_FOLDS);
    end

    assign w_free = !r_fuse_valid || bus.fuse_ready;
    assign w_req  = w_elig & {NUM_MODALITY{w_free}};

    rr_arbiter #(
        .N     (NUM_MODALITY),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .gnt     (w_gnt),
        .idx     (w_idx),
        .gnt_any (w_any)
    );

    // w_all_full looks one beat ahead so the FSM leaves COLLECT in the same
    // cycle the final fold is granted.
    always_comb begin
        w_all_full = 1'b1;
        w_any_cnt  = 1'b0;
        for (int m = 0; m < NUM_MODALITY; m++) begin
            if (({1'b0, r_fcnt[m]} + {{c_CNT_W{1'b0}}, w_gnt[m]}) != c_FOLDS_EXT) begin
                w_all_full = 1'b0;
            end
            if (r_fcnt[m] != '0) begin
                w_any_cnt = 1'b1;
            end
        end
    end

    // Done is only asserted while the consumer is ready, so it can never
    // stay high across cycles and wipe the fuser's accumulator.
    assign w_emit_fire = !rst && (r_state == c_EMIT) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < NUM_MODALITY; m++) begin
                r_fcnt[m] <= '0;
            end
        end else if (w_emit_fire) begin
            for (int m = 0; m < NUM_MODALITY; m++) begin
                r_fcnt[m] <= '0;
            end
        end else if (w_any) begin
            r_fcnt[w_idx] <= r_fcnt[w_idx] + c_CNT_W'(1);
        end
    end

    // Output register: loads on grant, empties when free without a grant,
    // holds every field while stalled by the fuser.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fuse_valid <= 1'b0;
            r_fuse_hv    <= '0;
            r_fuse_fold  <= '0;
        end else if (w_free) begin
            r_fuse_valid <= w_any;
            if (w_any) begin
                r_fuse_hv   <= w_hv[w_idx];
                r_fuse_fold <= NUM_FOLDS_WIDTH'(r_fcnt[w_idx]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_COLLECT;
        end else begin
            case (r_state)
                c_COLLECT: if (w_all_full)                          r_state <= c_DRAIN;
                c_DRAIN:   if (!r_fuse_valid || bus.fuse_ready)     r_state <= c_EMIT;
                c_EMIT:    if (bus.out_ready)                       r_state <= c_COLLECT;
                default:                                            r_state <= c_COLLECT;
            endcase
        end
    end

    assign bus.mod_ready  = w_gnt;
    assign bus.fuse_valid = r_fuse_valid;
    assign bus.fuse_hv    = r_fuse_hv;
    assign bus.fuse_fold  = r_fuse_fold;
    assign bus.fuse_done  = w_emit_fire;
    assign bus.busy       = w_any_cnt || (r_state != c_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_fuser_fold_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fuser_fold_scheduler
//  Description : Self-checking bench for fuser_fold_scheduler. A folded
//                instance (3 modalities x 10 folds x 200 bits) is driven by
//                a cycle model plus scoreboard; an unfolded instance
//                (3 x 1 x 2000 bits) is exercised separately.
//  Config      : FUSER_SCHED_RR_EN - expected arbitration order follows it
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fuser_fold_scheduler;

    localparam int M  = 3;
    localparam int F  = 10;
    localparam int FW = 200;

    logic clk;
    logic rst;

    fuser_fold_scheduler_if #(.NUM_MODALITY(M), .NUM_FOLDS_WIDTH(4), .FOLD_WIDTH(FW))   bus0 ();
    fuser_fold_scheduler_if #(.NUM_MODALITY(M), .NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(2000)) bus1 ();

    fuser_fold_scheduler #(
        .NUM_MODALITY(M), .NUM_FOLDS(F), .NUM_FOLDS_WIDTH(4), .FOLD_WIDTH(FW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    fuser_fold_scheduler #(
        .NUM_MODALITY(M), .NUM_FOLDS(1), .NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(2000)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Stimulus / encoder state
    bit [M-1:0] want;
    int enc_fold [M];

    // Reference model of the scheduler
    int m_fcnt [M];
    int m_ptr;
    int m_state;     // 0 collect, 1 drain, 2 emit
    bit m_valid;

    // Scoreboard and statistics
    int sb_m [$];
    int sb_f [$];
    int gorder [$];
    int seen [M][F];
    int beats, dones, grants, cyc_n, last_beat_cyc, done_cyc;

    function automatic logic [FW-1:0] pat(input int m, input int f);
        logic [7:0] b;
        b = 8'(m * 16 + f) ^ 8'hA5;
        return {25{b}} ^ (FW'(f + 1) << (m * 50));
    endfunction

    function automatic logic [1999:0] pat1(input int m);
        logic [7:0] b;
        b = 8'(m * 16 + 9) ^ 8'h3C;
        return {250{b}};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            m_fcnt[m]   = 0;
            enc_fold[m] = 0;
        end
        m_ptr   = 0;
        m_state = 0;
        m_valid = 1'b0;
        sb_m.delete();
        sb_f.delete();
    endtask

    task automatic clear_stats();
        beats  = 0;
        dones  = 0;
        grants = 0;
        gorder.delete();
        for (int m = 0; m < M; m++)
            for (int f = 0; f < F; f++)
                seen[m][f] = 0;
    endtask

    // One clock cycle on the folded instance. Called at a falling edge with
    // fuse_ready/out_ready/want already set; returns at the next falling edge.
    task automatic cyc();
        int         g, c, em, ef;
        bit         free, ed, eb, all_full, old_valid;
        bit [M-1:0] eg;
        for (int m = 0; m < M; m++) begin
            bus0.mod_valid[m]          = want[m];
            bus0.mod_hv[m*FW +: FW]    = pat(m, enc_fold[m]);
        end
        #1;
        free = !m_valid || bus0.fuse_ready;
        g    = -1;
        if (m_state == 0 && free) begin
            for (int k = 0; k < M; k++) begin
`ifdef FUSER_SCHED_RR_EN
                c = (m_ptr + k) % M;
`else
                c = k;
`endif
                if (g < 0 && want[c] && m_fcnt[c] < F) g = c;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        ed = (m_state == 2) && bus0.out_ready;
        eb = (m_state != 0);
        for (int m = 0; m < M; m++) if (m_fcnt[m] != 0) eb = 1'b1;

        n_total++;
        if (bus0.mod_ready !== eg)
            $display("FAIL mod_ready cyc%0d: got %b, required %b", cyc_n, bus0.mod_ready, eg);
        else n_pass++;
        n_total++;
        if (bus0.fuse_valid !== m_valid)
            $display("FAIL fuse_valid cyc%0d: got %b, required %b", cyc_n, bus0.fuse_valid, m_valid);
        else n_pass++;
        n_total++;
        if (bus0.fuse_done !== ed)
            $display("FAIL fuse_done cyc%0d: got %b, required %b", cyc_n, bus0.fuse_done, ed);
        else n_pass++;
        n_total++;
        if (bus0.busy !== eb)
            $display("FAIL busy cyc%0d: got %b, required %b", cyc_n, bus0.busy, eb);
        else n_pass++;

        if (bus0.fuse_valid === 1'b1 && bus0.fuse_ready) begin
            n_total++;
            if (sb_m.size() == 0) begin
                $display("FAIL beat_unexpected cyc%0d: got fold %0d, required no beat", cyc_n, bus0.fuse_fold);
            end else begin
                em = sb_m.pop_front();
                ef = sb_f.pop_front();
                if (bus0.fuse_fold !== 4'(ef) || bus0.fuse_hv !== pat(em, ef)) begin
                    $display("FAIL beat cyc%0d: got fold %0d hv[15:0]=%h, required m%0d fold %0d hv[15:0]=%h",
                             cyc_n, bus0.fuse_fold, bus0.fuse_hv[15:0], em, ef, pat(em, ef) & 200'hFFFF);
                end else begin
                    n_pass++;
                    seen[em][ef]++;
                    beats++;
                    last_beat_cyc = cyc_n;
                end
            end
        end
        if (bus0.fuse_done === 1'b1) begin
            dones++;
            done_cyc = cyc_n;
        end

        if (g >= 0) begin
            sb_m.push_back(g);
            sb_f.push_back(m_fcnt[g]);
            gorder.push_back(g);
            grants++;
        end

        old_valid = m_valid;
        if (g >= 0) begin
            m_fcnt[g]++;
            m_ptr = (g + 1) % M;
        end
        if (free) m_valid = (g >= 0);
        case (m_state)
            0: begin
                all_full = 1'b1;
                for (int m = 0; m < M; m++) if (m_fcnt[m] != F) all_full = 1'b0;
                if (all_full) m_state = 1;
            end
            1: if (!old_valid || bus0.fuse_ready) m_state = 2;
            2: if (bus0.out_ready) begin
                m_state = 0;
                for (int m = 0; m < M; m++) m_fcnt[m] = 0;
            end
            default: m_state = 0;
        endcase

        for (int m = 0; m < M; m++) if (bus0.mod_ready[m] === 1'b1) enc_fold[m]++;
        if (bus0.fuse_done === 1'b1) for (int m = 0; m < M; m++) enc_fold[m] = 0;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run_until_done(input int budget);
        int d0, i;
        d0 = dones;
        i  = 0;
        while (dones == d0 && i < budget) begin
            cyc();
            i++;
        end
        n_total++;
        if (dones == d0) $display("FAIL done_timeout: no fuse_done within %0d cycles, required one", budget);
        else n_pass++;
    endtask

    task automatic check_pairs(input string tag);
        int bad;
        bad = 0;
        for (int m = 0; m < M; m++)
            for (int f = 0; f < F; f++)
                if (seen[m][f] != 1) bad++;
        n_total++;
        if (bad != 0) $display("FAIL %s_pairs: %0d (modality,fold) pairs not seen exactly once, required 0", tag, bad);
        else n_pass++;
        n_total++;
        if (beats != M * F) $display("FAIL %s_beats: got %0d beats, required %0d", tag, beats, M * F);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if (bus0.fuse_valid !== 1'b0 || bus0.fuse_hv !== '0 || bus0.fuse_fold !== 4'd0 ||
            bus0.fuse_done !== 1'b0 || bus0.mod_ready !== 3'b000 || bus0.busy !== 1'b0)
            $display("FAIL %s: got valid=%b hv_nz=%b fold=%0d done=%b ready=%b busy=%b, required all 0",
                     tag, bus0.fuse_valid, |bus0.fuse_hv, bus0.fuse_fold, bus0.fuse_done,
                     bus0.mod_ready, bus0.busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        want = 3'b111;
        bus0.mod_valid = 3'b111;
        bus0.fuse_ready = 1'b1;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_values");
        n_total++;
        if (bus1.fuse_valid !== 1'b0 || bus1.fuse_done !== 1'b0 || bus1.mod_ready !== 3'b000)
            $display("FAIL reset_unfolded: got valid=%b done=%b ready=%b, required 0/0/000",
                     bus1.fuse_valid, bus1.fuse_done, bus1.mod_ready);
        else n_pass++;
        rst = 1'b0;
        want = '0;
        model_reset();
    endtask

    task automatic test_sequential();
        int e1, e2;
        clear_stats();
        want = 3'b111;
        bus0.fuse_ready = 1'b1;
        bus0.out_ready = 1'b1;
        run_until_done(60);
        check_pairs("sequential");
        n_total++;
        if (dones != 1) $display("FAIL sequential_dones: got %0d, required 1", dones);
        else n_pass++;
        n_total++;
        if (done_cyc != last_beat_cyc + 1)
            $display("FAIL sequential_done_timing: got cycle %0d, required %0d", done_cyc, last_beat_cyc + 1);
        else n_pass++;
`ifdef FUSER_SCHED_RR_EN
        e1 = 1; e2 = 2;
`else
        e1 = 0; e2 = 0;
`endif
        n_total++;
        if (gorder.size() < 3 || gorder[1] != e1 || gorder[2] != e2)
            $display("FAIL sequential_order: got grants %0d,%0d, required %0d,%0d",
                     (gorder.size() > 1) ? gorder[1] : -1, (gorder.size() > 2) ? gorder[2] : -1, e1, e2);
        else n_pass++;
    endtask

    task automatic test_sparse();
        int other;
        clear_stats();
        want = 3'b010;
        repeat (5) cyc();
        want = 3'b000;
        cyc();
        other = 0;
        for (int f = 0; f < F; f++) other += seen[0][f] + seen[2][f];
        n_total++;
        if (beats != 5 || seen[1][0] != 1 || seen[1][4] != 1)
            $display("FAIL sparse_beats: got %0d beats (f0=%0d f4=%0d), required 5 (1,1)",
                     beats, seen[1][0], seen[1][4]);
        else n_pass++;
        n_total++;
        if (other != 0) $display("FAIL sparse_others: got %0d beats from m0/m2, required 0", other);
        else n_pass++;
        n_total++;
        if (dones != 0) $display("FAIL sparse_done: got %0d dones, required 0", dones);
        else n_pass++;
        want = 3'b111;
        run_until_done(60);
        check_pairs("sparse_complete");
    endtask

    task automatic test_back_to_back_backpressure();
        logic [FW-1:0] hv0;
        logic [3:0]    f0;
        clear_stats();
        want = 3'b111;
        bus0.fuse_ready = 1'b1;
        repeat (6) cyc();
        bus0.fuse_ready = 1'b0;
        hv0 = bus0.fuse_hv;
        f0  = bus0.fuse_fold;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_total++;
            if (bus0.fuse_hv !== hv0 || bus0.fuse_fold !== f0 || bus0.fuse_valid !== 1'b1)
                $display("FAIL stall_hold %0d: got fold %0d valid %b, required fold %0d valid 1",
                         i, bus0.fuse_fold, bus0.fuse_valid, f0);
            else n_pass++;
            n_total++;
            if (bus0.mod_ready !== 3'b000)
                $display("FAIL stall_ready %0d: got %b, required 000", i, bus0.mod_ready);
            else n_pass++;
        end
        bus0.fuse_ready = 1'b1;
        run_until_done(60);
        check_pairs("backpressure");
        n_total++;
        if (grants != M * F) $display("FAIL backpressure_grants: got %0d, required %0d", grants, M * F);
        else n_pass++;
    endtask

    task automatic test_output_stall();
        int i;
        clear_stats();
        want = 3'b111;
        bus0.out_ready = 1'b0;
        i = 0;
        while (m_state != 2 && i < 60) begin
            cyc();
            i++;
        end
        n_total++;
        if (m_state != 2) $display("FAIL stall_reach_emit: not in EMIT after %0d cycles, required EMIT", i);
        else n_pass++;
        repeat (4) begin
            cyc();
            n_total++;
            if (bus0.fuse_done !== 1'b0 || bus0.mod_ready !== 3'b000)
                $display("FAIL emit_wait: got done=%b ready=%b, required 0/000", bus0.fuse_done, bus0.mod_ready);
            else n_pass++;
        end
        n_total++;
        if (dones != 0) $display("FAIL emit_wait_dones: got %0d, required 0", dones);
        else n_pass++;
        bus0.out_ready = 1'b1;
        cyc();
        want = 3'b000;
        cyc();
        n_total++;
        if (dones != 1) $display("FAIL emit_pulse: got %0d done cycles, required 1", dones);
        else n_pass++;
        check_pairs("output_stall");
    endtask

    task automatic test_abort();
        int i;
        clear_stats();
        want = 3'b111;
        i = 0;
        while (grants < 17 && i < 40) begin
            cyc();
            i++;
        end
        n_total++;
        if (grants != 17) $display("FAIL abort_setup: got %0d grants, required 17", grants);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_values");
        rst = 1'b0;
        model_reset();
        clear_stats();
        run_until_done(60);
        check_pairs("abort_restart");
        want = 3'b000;
    endtask

    task automatic test_unfolded();
        int q [$];
        int b1, d1, dc, em;
        bit [M-1:0] sent;
        q = '{0, 1, 2};
        b1 = 0; d1 = 0; dc = -1;
        sent = '0;
        bus1.fuse_ready = 1'b1;
        bus1.out_ready  = 1'b1;
        for (int m = 0; m < M; m++) bus1.mod_hv[m*2000 +: 2000] = pat1(m);
        for (int c = 0; c < 10; c++) begin
            bus1.mod_valid = ~sent;
            #1;
            if (bus1.fuse_valid === 1'b1) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL unfolded_extra: got beat at cycle %0d, required none", c);
                end else begin
                    em = q.pop_front();
                    if (bus1.fuse_fold !== 1'b0 || bus1.fuse_hv !== pat1(em))
                        $display("FAIL unfolded_beat: got fold %0d hv[7:0]=%h, required fold 0 hv[7:0]=%h",
                                 bus1.fuse_fold, bus1.fuse_hv[7:0], pat1(em) & 2000'hFF);
                    else begin
                        n_pass++;
                        b1++;
                    end
                end
            end
            if (bus1.fuse_done === 1'b1) begin
                d1++;
                dc = c;
            end
            sent = sent | bus1.mod_ready;
            @(negedge clk);
        end
        bus1.mod_valid = '0;
        n_total++;
        if (b1 != 3) $display("FAIL unfolded_beats: got %0d, required 3", b1);
        else n_pass++;
        n_total++;
        if (d1 != 1 || dc != 4) $display("FAIL unfolded_done: got %0d pulses at cycle %0d, required 1 at 4", d1, dc);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        want = '0;
        cyc_n = 0;
        bus0.mod_valid = '0;
        bus0.mod_hv = '0;
        bus0.fuse_ready = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.mod_valid = '0;
        bus1.mod_hv = '0;
        bus1.fuse_ready = 1'b0;
        bus1.out_ready = 1'b0;
        model_reset();
        clear_stats();
        @(negedge clk);

        test_reset();
        test_sequential();
        test_sparse();
        test_back_to_back_backpressure();
        test_output_stall();
        test_abort();
        test_unfolded();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
